aes_round_ctrl: RTL
===================

# aes_round_ctrl

Iterative AES-128 encryption sequencer that owns one combinational round datapath (`aes_round`) and time-multiplexes it across all ten rounds of a block. It accepts a plaintext/key pair over a valid/ready handshake and performs the initial AddRoundKey. It then expands round keys on the fly, using an external combinational S-box through a SubWord port, and steps the datapath one round per clock, asserting `last_round` on round 10. The ciphertext is returned over a second valid/ready handshake. The block sits between the bus-side block buffer and the shared round datapath.

## Interface
Parameters: none (AES-128 only; 10 rounds fixed).

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: plaintext/key offered.
- `in_ready` out 1: block accepts; high only in IDLE.
- `plaintext` in 128: byte 0 = [127:120].
- `key` in 128: cipher key; word 0 = [127:96].
- `out_valid` out 1: ciphertext valid.
- `out_ready` in 1: consumer accepts ciphertext.
- `ciphertext` out 128: result; held stable while `out_valid` is high.
- `rnd_state_in` out 128: to datapath `state_in`; equals the state register.
- `rnd_key` out 128: to datapath `round_key`; combinational next round key.
- `rnd_last` out 1: to datapath `last_round`; high when round == 10.
- `rnd_state_out` in 128: from datapath `state_out`.
- `kx_word` out 32: RotWord of key-register word 3, i.e. {w3[23:0], w3[31:24]}, sent to the S-box.
- `kx_sub` in 32: combinational SubWord(`kx_word`) from the S-box.
- `busy` out 1: high in RUN or DONE.
- `round` out 4: current round number, 1..10 in RUN; 0 otherwise.

## Operation
- Registers:
  - `state_q` (128)
  - `key_q` (128)
  - `rcon_q` (8)
  - `round_q` (4)
  - FSM {IDLE, RUN, DONE}
- Key step (combinational), with t = `kx_sub` ^ {`rcon_q`, 24'h0}:
  - n0 = w0^t
  - n1 = w1^n0
  - n2 = w2^n1
  - n3 = w3^n2
  - `rnd_key` = {n0, n1, n2, n3}
- IDLE:
  - `in_ready` = 1.
  - On `in_valid` & `in_ready`: `state_q` <= `plaintext` ^ `key`; `key_q` <= `key`; `rcon_q` <= 8'h01; `round_q` <= 1; go to RUN.
- RUN, each cycle:
  - `state_q` <= `rnd_state_out`; `key_q` <= `rnd_key`.
  - `rcon_q` <= xtime(`rcon_q`) = {r[6:0], 0} ^ (r[7] ? 8'h1b : 0).
  - `round_q` increments.
  - When `round_q` == 10: go to DONE and leave `round_q` at 0.
- DONE:
  - `out_valid` = 1; `ciphertext` = `state_q`.
  - On `out_ready`: go to IDLE.
- Inputs while not IDLE: `in_valid` is ignored; `plaintext` and `key` are not sampled.
- Datapath outputs outside RUN: `rnd_*` outputs remain driven from the registers. Their values are don't-care; only `rnd_last` must be 0 outside RUN.
- Rcon sequence across rounds 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.

## Timing
- Reset (asynchronous, any state including mid-RUN):
  - FSM = IDLE; `state_q`, `key_q`, `round_q`, `rcon_q` = 0.
  - `out_valid` = 0, `busy` = 0, `round` = 0, `rnd_last` = 0.
  - `in_ready` = 1 after release.
  - Any in-flight block is discarded with no output.
- Latency: input handshake at edge E0; rounds 1..10 are applied at edges E1..E10; `out_valid` is high from E10.
- Throughput:
  - With `out_ready` held high: DONE lasts 1 cycle, IDLE accepts at the following edge.
  - Minimum input-handshake spacing is 12 cycles.
- `out_ready` low: DONE persists indefinitely; `ciphertext` is unchanged and `in_ready` stays 0.
- `out_valid` must not drop without a handshake.
- `rnd_last` is high for exactly one cycle per block, the cycle before E10.
- `round` is combinationally equal to `round_q` and visible on the same cycle as `rnd_key`.

## Test plan
- Key schedule:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c with a bench FIPS S-box.
  - Required: `rnd_key` during round 1 = a0fafe1788542cb123a339392a6c7605; during round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- End-to-end:
  - Stimulus: plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, with the real `aes_round` and S-box.
  - Required: `ciphertext` equals the bench golden model of the same datapath composed with FIPS key expansion.
  - Required: `out_valid` rises exactly 10 cycles after acceptance.
- Backpressure:
  - Stimulus: hold `out_ready` = 0 for 20 cycles after `out_valid`, and pulse `in_valid` with new data during that window.
  - Required: `ciphertext` stable, `in_ready` = 0, new data not taken; it is accepted 1 cycle after `out_ready` rises.
- Back-to-back:
  - Stimulus: 3 blocks with `in_valid` and `out_ready` held high.
  - Required: input handshakes 12 cycles apart; results in order, each matching the model.
- Reset mid-operation:
  - Stimulus: deassert `rst_n` asynchronously (between edges) at round 5.
  - Required: `out_valid`/`busy`/`round` go to 0 immediately.
  - Required: after release, a new block completes correctly, with rcon restarting at 01 (check `rnd_key` in round 1).
- Round/last sequencing:
  - Stimulus: monitor `round` and `rnd_last` over one block.
  - Required: `round` counts 1..10; `rnd_last` is high only when `round` = 10; both read 0 in IDLE and DONE.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
//
// Iterative AES-128 encryption sequencer. It owns no round logic itself: it
// drives one external combinational round datapath (aes_round) once per clock
// for rounds 1..10. It expands the round keys on the fly through an external
// combinational S-box on the SubWord port.
//
// Handshakes (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. The producer holds valid and its data stable
// until that edge. in_ready is high only in IDLE. out_valid is high only in
// DONE, and ciphertext is held there until the consumer takes it.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready plaintext/key handshake (plaintext, key)
//   out_valid/out_ready ciphertext handshake (ciphertext)
//   rnd_state_in      state register to datapath state_in
//   rnd_key           next round key (combinational) to datapath round_key
//   rnd_last          datapath last_round, high during round 10 only
//   rnd_state_out     datapath result
//   kx_word/kx_sub    RotWord(w3) to the S-box, SubWord result back
//   busy              high in RUN or DONE
//   round             current round 1..10 in RUN, 0 otherwise
//   dbg_state         FSM state (0 IDLE, 1 RUN, 2 DONE) for observation
// ---------------------------------------------------------------------------
module aes_round_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic [127:0] rnd_state_in,
    output logic [127:0] rnd_key,
    output logic         rnd_last,
    input  logic [127:0] rnd_state_out,
    output logic [31:0]  kx_word,
    input  logic [31:0]  kx_sub,
    output logic         busy,
    output logic [3:0]   round,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         r_fsm;
    state_t         w_fsm_nxt;
    logic [127:0]   r_state;
    logic [127:0]   r_key;
    logic [7:0]     r_rcon;
    logic [3:0]     r_round;

    logic [127:0]   w_state_nxt;
    logic [127:0]   w_key_nxt;
    logic [7:0]     w_rcon_nxt;
    logic [3:0]     w_round_nxt;

    logic [31:0]    w_w0, w_w1, w_w2, w_w3;
    logic [31:0]    w_t;
    logic [31:0]    w_n0, w_n1, w_n2, w_n3;
    logic [127:0]   w_rnd_key;
    logic [7:0]     w_rcon_xtime;

    // Key step: the key register always holds the previous round key, so the
    // key for the round being applied this cycle is derived combinationally.
    assign w_w0 = r_key[127:96];
    assign w_w1 = r_key[95:64];
    assign w_w2 = r_key[63:32];
    assign w_w3 = r_key[31:0];

    assign kx_word   = {w_w3[23:0], w_w3[31:24]};
    assign w_t       = kx_sub ^ {r_rcon, 24'h000000};
    assign w_n0      = w_w0 ^ w_t;
    assign w_n1      = w_w1 ^ w_n0;
    assign w_n2      = w_w2 ^ w_n1;
    assign w_n3      = w_w3 ^ w_n2;
    assign w_rnd_key = {w_n0, w_n1, w_n2, w_n3};

    // Multiply rcon by x in GF(2^8); 0x80 wraps to 0x1b for round 9.
    assign w_rcon_xtime = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= ST_IDLE;
            r_state <= 128'h0;
            r_key   <= 128'h0;
            r_rcon  <= 8'h00;
            r_round <= 4'd0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
            r_rcon  <= w_rcon_nxt;
            r_round <= w_round_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_rcon_nxt  = r_rcon;
        w_round_nxt = r_round;
        case (r_fsm)
            ST_IDLE: begin
                if (in_valid) begin
                    // Initial AddRoundKey happens on acceptance.
                    w_state_nxt = plaintext ^ key;
                    w_key_nxt   = key;
                    w_rcon_nxt  = 8'h01;
                    w_round_nxt = 4'd1;
                    w_fsm_nxt   = ST_RUN;
                end
            end
            ST_RUN: begin
                w_state_nxt = rnd_state_out;
                w_key_nxt   = w_rnd_key;
                w_rcon_nxt  = w_rcon_xtime;
                if (r_round == 4'd10) begin
                    w_round_nxt = 4'd0;
                    w_fsm_nxt   = ST_DONE;
                end else begin
                    w_round_nxt = r_round + 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_fsm_nxt = ST_IDLE;
                end
            end
            default: begin
                w_fsm_nxt = ST_IDLE;
            end
        endcase
    end

    assign in_ready     = (r_fsm == ST_IDLE);
    assign out_valid    = (r_fsm == ST_DONE);
    assign busy         = (r_fsm != ST_IDLE);
    assign ciphertext   = r_state;
    assign rnd_state_in = r_state;
    assign rnd_key      = w_rnd_key;
    // round_q is already 0 outside RUN; the FSM term makes that explicit.
    assign rnd_last     = (r_fsm == ST_RUN) && (r_round == 4'd10);
    assign round        = r_round;
    assign dbg_state    = r_fsm;

endmodule
